hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Produces the stall, flush and forwarding selects, including FlushE, which drives the clear input of the decode-to-execute pipeline register.
- Includes sequential debug logic: saturating stall and flush counters, and a sticky watchdog that flags a pipeline stalled for too long.
- Sits beside the datapath and takes register indices and control bits from the D, E, M and W stages.

Parameters:
- CNT_W, 32: width of the perf counters.
- MAX_STALL, 8: number of consecutive StallD cycles that sets hang_err. Legal range 1 to 255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- RsD, RtD  in  5  source registers in D
- RsE, RtE  in  5  source registers in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables
- MemtoRegE, MemtoRegM  in  1  load in E / load in M
- BranchD  in  1  branch being decoded
- PCSrcD  in  1  branch taken (resolved in D)
- perf_clr  in  1  synchronous clear of counters, streak and hang_err
- StallF, StallD  out  1  hold PC / hold F->D register
- FlushD  out  1  clear F->D register
- FlushE  out  1  clear D->E register
- ForwardAE, ForwardBE  out  2  E-stage ALU operand select
- ForwardAD, ForwardBD  out  1  D-stage comparator forward from M
- stall_cnt, flush_cnt  out  CNT_W  perf counters
- hang_err  out  1  sticky watchdog flag

Behaviour:
- Hazard outputs are combinational, same cycle as their inputs. Counters, streak and hang_err are registered.
- Register 0 never matches in any comparison below.
- ForwardAE:
  - 2'b10 if RsE==WriteRegM and RegWriteM.
  - Otherwise 2'b01 if RsE==WriteRegW and RegWriteW.
  - Otherwise 2'b00.
  - M has priority when both stages match.
- ForwardBE: same rule using RtE.
- ForwardAD = RsD==WriteRegM and RegWriteM. ForwardBD uses RtD.
- lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
- brstall = BranchD and either:
  - RegWriteE and WriteRegE matches RsD or RtD, or
  - MemtoRegM and WriteRegM matches RsD or RtD.
- StallF = StallD = FlushE = lwstall or brstall.
- FlushD = PCSrcD and not StallD. A stall takes priority over the redirect.
- While reset is high:
  - StallF, StallD and FlushD are forced to 0.
  - FlushE is forced to 1.
  - All Forward* outputs are forced to 0.
- Register reset values: stall_cnt=0, flush_cnt=0, streak=0, hang_err=0.
- Counters (each posedge, reset not asserted):
  - If perf_clr: all counters, streak and hang_err go to 0. perf_clr overrides increments on the same edge.
  - Otherwise stall_cnt += StallD and flush_cnt += FlushE.
  - Both counters saturate at all-ones and never wrap.
- Watchdog:
  - streak is 8 bits.
  - streak increments on each edge where StallD=1 and saturates at MAX_STALL.
  - streak goes to 0 on any edge where StallD=0.
  - hang_err is set on the edge where StallD=1 and streak==MAX_STALL-1, i.e. after MAX_STALL consecutive stalled cycles.
  - Once set, hang_err stays 1 until reset or perf_clr.
- Asserting reset mid-streak clears all state immediately.

Decomposition:
- Shared pipeline package holds:
  - typedef reg_idx_t (5 bits).
  - typedef fwd_sel_t (2 bits), with constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One natural sub-module: hazard_perf, containing the two saturating counters and the watchdog. It is parameterized by CNT_W and MAX_STALL.

Test Plan:
- Forward priority: RsE=5 with WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for that cycle. Next cycle with MemtoRegE=0 -> all 0. stall_cnt=1, flush_cnt=1.
- Branch stall vs redirect: BranchD=1, PCSrcD=1, RegWriteE=1, WriteRegE=RtD=3 -> StallD=1, FlushD=0. Remove the hazard -> FlushD=1, StallD=0.
- Watchdog: MAX_STALL=4, hold lwstall for 3 cycles -> hang_err=0. Hold for a 4th cycle -> hang_err=1 and stays 1 after the stall drops. Pulse perf_clr -> hang_err=0 and counters=0.
- Saturation: CNT_W=4, stall for 20 cycles (MAX_STALL=255) -> stall_cnt=15 and no wrap. perf_clr concurrent with a stall -> 0.
- Async reset: assert reset mid-stall between clock edges -> counters and hang_err are 0 immediately, FlushE=1, StallF=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard unit: register indices, forward selects
// and the "real register" match helper used by every comparison.
package hazard_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  // $zero is hardwired, so writes to it are never a real dependency.
  function automatic logic idx_match(input reg_idx_t a, input reg_idx_t b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_perf.sv
// Debug counters beside the hazard unit: saturating stall/flush counts and a
// sticky watchdog that flags MAX_STALL consecutive stalled cycles.
module hazard_perf #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             perf_clr,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang_err
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [7:0]       STREAK_MAX  = 8'(MAX_STALL);
  localparam logic [7:0]       STREAK_LAST = 8'(MAX_STALL - 1);

  logic [7:0] streak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      streak    <= '0;
      hang_err  <= 1'b0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      streak    <= '0;
      hang_err  <= 1'b0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
      // Any unstalled cycle breaks the streak; only unbroken runs count.
      if (!stall)                     streak <= '0;
      else if (streak != STREAK_MAX)  streak <= streak + 1'b1;
      if (stall && (streak == STREAK_LAST)) hang_err <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline, with the
// debug counter/watchdog block attached to the final stall and flush signals.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             perf_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang_err
);

  logic     lwstall, brstall, stall;
  fwd_sel_t fwd_a, fwd_b;

  // Memory stage wins over writeback: it holds the more recent value.
  function automatic fwd_sel_t fwd_sel(input reg_idx_t src);
    if (RegWriteM && idx_match(src, WriteRegM))      return FWD_MEM;
    else if (RegWriteW && idx_match(src, WriteRegW)) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

  always_comb begin
    fwd_a   = fwd_sel(RsE);
    fwd_b   = fwd_sel(RtE);
    lwstall = MemtoRegE && (idx_match(RtE, RsD) || idx_match(RtE, RtD));
    brstall = BranchD &&
              ((RegWriteE && (idx_match(WriteRegE, RsD) || idx_match(WriteRegE, RtD))) ||
               (MemtoRegM && (idx_match(WriteRegM, RsD) || idx_match(WriteRegM, RtD))));
    stall   = lwstall || brstall;
  end

  // While in reset the D->E register is held clear and nothing stalls.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      StallF    = stall;
      StallD    = stall;
      FlushE    = stall;
      FlushD    = PCSrcD && !stall;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      ForwardAD = RegWriteM && idx_match(RsD, WriteRegM);
      ForwardBD = RegWriteM && idx_match(RtD, WriteRegM);
    end
  end

  hazard_perf #(
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .perf_clr  (perf_clr),
    .stall     (StallD),
    .flush     (FlushE),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .hang_err  (hang_err)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus, one with a
// short watchdog (MAX_STALL=4) and one with 4-bit saturating counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, perf_clr;

  logic        StallF_a, StallD_a, FlushD_a, FlushE_a, ForwardAD_a, ForwardBD_a, hang_a;
  logic [1:0]  ForwardAE_a, ForwardBE_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;

  logic        StallF_b, StallD_b, FlushD_b, FlushE_b, ForwardAD_b, ForwardBD_b, hang_b;
  logic [1:0]  ForwardAE_b, ForwardBE_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .MAX_STALL(4)) dut_a (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .PCSrcD(PCSrcD), .perf_clr(perf_clr),
    .StallF(StallF_a), .StallD(StallD_a), .FlushD(FlushD_a), .FlushE(FlushE_a),
    .ForwardAE(ForwardAE_a), .ForwardBE(ForwardBE_a),
    .ForwardAD(ForwardAD_a), .ForwardBD(ForwardBD_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .hang_err(hang_a)
  );

  hazard_ctrl #(.CNT_W(4), .MAX_STALL(255)) dut_b (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .PCSrcD(PCSrcD), .perf_clr(perf_clr),
    .StallF(StallF_b), .StallD(StallD_b), .FlushD(FlushD_b), .FlushE(FlushE_b),
    .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b),
    .ForwardAD(ForwardAD_b), .ForwardBD(ForwardBD_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .hang_err(hang_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_use(input logic on);
    MemtoRegE = on; RtE = 5'd8; RsD = 5'd8;
  endtask

  initial begin
    reset = 1'b1; perf_clr = 1'b0;
    clear_inputs();
    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    load_use(1'b1);
    #1;
    check("rst_flushe", 32'(FlushE_a), 1);
    check("rst_stallf", 32'(StallF_a), 0);
    check("rst_fwdae", 32'(ForwardAE_a), 0);
    check("rst_stall_cnt", stall_cnt_a, 0);
    tick(2);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("idle_flushe", 32'(FlushE_a), 0);

    // forwarding priority and $zero
    RsE = 5; RtE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1; #1;
    check("fwd_ae_mem", 32'(ForwardAE_a), 32'b10);
    check("fwd_be_mem", 32'(ForwardBE_a), 32'b10);
    RegWriteM = 0; #1;
    check("fwd_ae_wb", 32'(ForwardAE_a), 32'b01);
    RsE = 0; #1;
    check("fwd_ae_rf", 32'(ForwardAE_a), 32'b00);
    WriteRegW = 0; RegWriteW = 1; #1;
    check("fwd_ae_zero", 32'(ForwardAE_a), 32'b00);
    RsD = 5; RtD = 7; WriteRegM = 5; RegWriteM = 1; #1;
    check("fwd_ad", 32'(ForwardAD_a), 1);
    check("fwd_bd_nomatch", 32'(ForwardBD_a), 0);
    RtD = 5; #1;
    check("fwd_bd", 32'(ForwardBD_a), 1);
    clear_inputs();

    // load-use stall, then released
    load_use(1'b1); #1;
    check("lw_stallf", 32'(StallF_a), 1);
    check("lw_stalld", 32'(StallD_a), 1);
    check("lw_flushe", 32'(FlushE_a), 1);
    tick(1);
    load_use(1'b0); #1;
    check("lw_off_stalld", 32'(StallD_a), 0);
    check("lw_off_flushe", 32'(FlushE_a), 0);
    check("lw_stall_cnt", stall_cnt_a, 1);
    check("lw_flush_cnt", flush_cnt_a, 1);
    MemtoRegE = 1; RtE = 0; RsD = 0; #1;
    check("lw_zero_reg", 32'(StallD_a), 0);
    clear_inputs();

    // branch stall beats redirect
    BranchD = 1; PCSrcD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; #1;
    check("br_stalld", 32'(StallD_a), 1);
    check("br_flushd", 32'(FlushD_a), 0);
    WriteRegE = 4; #1;
    check("br_redirect_flushd", 32'(FlushD_a), 1);
    check("br_redirect_stalld", 32'(StallD_a), 0);
    RegWriteE = 0; MemtoRegM = 1; WriteRegM = 6; RsD = 6; #1;
    check("br_load_m_stall", 32'(StallD_a), 1);
    clear_inputs();
    tick(1);

    // broken streaks never trip the watchdog (stall_cnt_a 1 -> 7)
    load_use(1'b1); tick(3);
    load_use(1'b0); tick(1);
    load_use(1'b1); tick(3);
    load_use(1'b0); tick(1);
    check("wd_broken_streak", 32'(hang_a), 0);
    check("wd_broken_cnt", stall_cnt_a, 7);

    // watchdog trips on the 4th consecutive stall and sticks
    load_use(1'b1); tick(3);
    check("wd_3_stalls", 32'(hang_a), 0);
    tick(1);
    check("wd_4_stalls", 32'(hang_a), 1);
    check("wd_cnt", stall_cnt_a, 11);
    load_use(1'b0); tick(2);
    check("wd_sticky", 32'(hang_a), 1);
    check("wd_b_quiet", 32'(hang_b), 0);
    perf_clr = 1'b1; tick(1); perf_clr = 1'b0; #1;
    check("clr_hang", 32'(hang_a), 0);
    check("clr_stall_cnt", stall_cnt_a, 0);
    check("clr_flush_cnt", flush_cnt_a, 0);

    // 4-bit counters saturate at 15
    load_use(1'b1); tick(20);
    check("sat_stall_cnt_b", 32'(stall_cnt_b), 15);
    check("sat_flush_cnt_b", 32'(flush_cnt_b), 15);
    check("sat_stall_cnt_a", stall_cnt_a, 20);
    perf_clr = 1'b1; tick(1); perf_clr = 1'b0; #1;
    check("clr_vs_stall_b", 32'(stall_cnt_b), 0);
    check("clr_vs_stall_a", stall_cnt_a, 0);
    check("clr_vs_stall_hang", 32'(hang_a), 0);
    tick(1);
    check("post_clr_cnt_b", 32'(stall_cnt_b), 1);
    tick(3);
    check("post_clr_hang", 32'(hang_a), 1);
    check("post_clr_cnt_a", stall_cnt_a, 4);

    // async reset between edges, stall still requested
    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    #2 reset = 1'b1; #1;
    check("areset_stall_cnt", stall_cnt_a, 0);
    check("areset_flush_cnt", flush_cnt_a, 0);
    check("areset_hang", 32'(hang_a), 0);
    check("areset_flushe", 32'(FlushE_a), 1);
    check("areset_stallf", 32'(StallF_a), 0);
    check("areset_fwdae", 32'(ForwardAE_a), 0);
    tick(1);
    reset = 1'b0;
    clear_inputs(); #1;
    check("after_rst_cnt_b", 32'(stall_cnt_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
